// File: rtl/dav_rx_accum_if.sv
// dav_rx_accum_if: c/dav_/rfd channel plus the published block results.
// The producer side uses the master modport, the accumulator the slave modport.
// Optional feature macro: DAV_RX_MAX_EN adds the block-maximum result (max).
interface dav_rx_accum_if #(
    parameter int LOG2N = 3
);
    logic             dav_;
    logic [2:0]       c;
    logic             rfd;
    logic [LOG2N+2:0] sum;
    logic [2:0]       avg;
    logic             ok;
`ifdef DAV_RX_MAX_EN
    logic [2:0]       max;

    modport master (output dav_, c, input rfd, sum, avg, ok, max);
    modport slave  (input dav_, c, output rfd, sum, avg, ok, max);
`else
    modport master (output dav_, c, input rfd, sum, avg, ok);
    modport slave  (input dav_, c, output rfd, sum, avg, ok);
`endif
endinterface

// File: rtl/dav_rx_accum.sv
// dav_rx_accum: consumer end of a c/dav_/rfd channel. Takes one 3-bit sample
// per handshake, sums blocks of 2**LOG2N samples and publishes sum/avg with a
// one-cycle ok strobe. All outputs are registered.
// Optional feature macro: DAV_RX_MAX_EN (also tracks and publishes the block max).
module dav_rx_accum #(
    parameter int LOG2N = 3
) (
    input logic           clock,
    input logic           reset,
    dav_rx_accum_if.slave bus
);
    localparam int NSAMP = 1 << LOG2N;
    localparam int SW    = 3 + LOG2N;   // 7*NSAMP fits, so no overflow
    localparam int CW    = LOG2N + 1;   // must reach NSAMP itself

    typedef enum logic [1:0] {
        R0 = 2'd0,   // idle, waiting for dav_ low
        R1 = 2'd1,   // accept the captured sample
        R2 = 2'd2    // wait for the producer to release dav_
    } star_t;

    star_t         star, star_nxt;
    logic [SW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [2:0]    c_q;
    logic          rfd_q;
    logic          ok_q;
    logic [SW-1:0] sum_q;
    logic [2:0]    avg_q;
    logic          capture, accept, release_, close;
`ifdef DAV_RX_MAX_EN
    logic [2:0]    mx;
    logic [2:0]    max_q;
`endif

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) star <= R0;
        else       star <= star_nxt;
    end

    // Next state and the per-edge event strobes that steer the datapath.
    always_comb begin
        star_nxt = R0;
        capture  = 1'b0;
        accept   = 1'b0;
        release_ = 1'b0;
        close    = 1'b0;
        case (star)
            R0: begin
                if (!bus.dav_) begin
                    capture  = 1'b1;
                    star_nxt = R1;
                end else begin
                    star_nxt = R0;
                end
            end
            R1: begin
                accept   = 1'b1;
                star_nxt = R2;
            end
            R2: begin
                if (bus.dav_) begin
                    release_ = 1'b1;
                    close    = (cnt == CW'(NSAMP));
                    star_nxt = R0;
                end else begin
                    star_nxt = R2;
                end
            end
            default: star_nxt = R0;
        endcase
    end

    // Sample capture, accumulation and result publication.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            c_q   <= '0;
            acc   <= '0;
            cnt   <= '0;
            rfd_q <= 1'b1;
            ok_q  <= 1'b0;
            sum_q <= '0;
            avg_q <= '0;
        end else begin
            // ok is set only by the block-closing release, which lands in R0,
            // so the next edge always clears it again.
            ok_q <= close;
            if (capture) c_q <= bus.c;
            if (accept) begin
                rfd_q <= 1'b0;
                acc   <= acc + SW'(c_q);
                cnt   <= cnt + CW'(1);
            end
            if (release_) rfd_q <= 1'b1;
            if (close) begin
                sum_q <= acc;
                avg_q <= acc[LOG2N+2:LOG2N];
                acc   <= '0;
                cnt   <= '0;
            end
        end
    end

`ifdef DAV_RX_MAX_EN
    // Running block maximum (unsigned), published alongside sum/avg.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mx    <= '0;
            max_q <= '0;
        end else begin
            if (accept && (c_q > mx)) mx <= c_q;
            if (close) begin
                max_q <= mx;
                mx    <= '0;
            end
        end
    end

    assign bus.max = max_q;
`endif

    assign bus.rfd = rfd_q;
    assign bus.ok  = ok_q;
    assign bus.sum = sum_q;
    assign bus.avg = avg_q;

endmodule

// File: tb/tb_dav_rx_accum.sv
// Directed bench for dav_rx_accum (LOG2N=3): table of full handshakes plus
// hand-written sequences for long hold, back-to-back after ok, and mid-R2 reset.
// Builds with or without DAV_RX_MAX_EN.
module tb_dav_rx_accum;
    logic clock;
    logic reset;
    int   n_run;
    int   n_fail;

    dav_rx_accum_if #(.LOG2N(3)) bus ();

    dav_rx_accum #(.LOG2N(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] s;
        logic       ok;
        logic [5:0] sum;
        logic [2:0] avg;
        logic [2:0] mx;
    } vec_t;

    vec_t tbl [24];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_res(input string nm, input logic ok, input logic [5:0] sum,
                           input logic [2:0] avg, input logic [2:0] mx);
        chk({nm, "_ok"}, 8'(bus.ok), 8'(ok));
        chk({nm, "_sum"}, 8'(bus.sum), 8'(sum));
        chk({nm, "_avg"}, 8'(bus.avg), 8'(avg));
`ifdef DAV_RX_MAX_EN
        chk({nm, "_max"}, 8'(bus.max), 8'(mx));
`else
        if (mx > 3'd7) $display("unreachable");
`endif
    endtask

    task automatic setv(input int i, input logic [2:0] s, input logic ok,
                        input logic [5:0] sum, input logic [2:0] avg, input logic [2:0] mx);
        tbl[i].s   = s;
        tbl[i].ok  = ok;
        tbl[i].sum = sum;
        tbl[i].avg = avg;
        tbl[i].mx  = mx;
    endtask

    // One full transfer starting in an R0 cycle (#1 after an edge). c is
    // corrupted right after capture; hold extends the dav_ low time in R2.
    // Returns #1 after the edge that raises rfd.
    task automatic xfer(input logic [2:0] s, input int hold);
        bus.dav_ = 1'b0;
        bus.c    = s;
        chk("rfd_idle", 8'(bus.rfd), 8'd1);
        @(posedge clock); #1;
        bus.c = ~s;
        chk("rfd_r1", 8'(bus.rfd), 8'd1);
        @(posedge clock); #1;
        chk("rfd_fall", 8'(bus.rfd), 8'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clock); #1;
            chk("rfd_hold", 8'(bus.rfd), 8'd0);
        end
        bus.dav_ = 1'b1;
        @(posedge clock); #1;
        chk("rfd_rise", 8'(bus.rfd), 8'd1);
    endtask

    task automatic idle1();
        @(posedge clock); #1;
        chk("ok_one_cycle", 8'(bus.ok), 8'd0);
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;

        // block 1: 1..7,0 -> 28/3, max 7
        for (int i = 0; i < 8; i++)
            if (i < 7) setv(i, 3'(i + 1), 1'b0, 6'd0, 3'd0, 3'd0);
            else       setv(i, 3'd0, 1'b1, 6'd28, 3'd3, 3'd7);
        // block 2: eight 7s -> 56/7
        for (int i = 8; i < 16; i++)
            if (i < 15) setv(i, 3'd7, 1'b0, 6'd28, 3'd3, 3'd7);
            else        setv(i, 3'd7, 1'b1, 6'd56, 3'd7, 3'd7);
        // block 3: eight 0s -> 0/0, max 0
        for (int i = 16; i < 24; i++)
            if (i < 23) setv(i, 3'd0, 1'b0, 6'd56, 3'd7, 3'd7);
            else        setv(i, 3'd0, 1'b1, 6'd0, 3'd0, 3'd0);

        reset    = 1'b1;
        bus.dav_ = 1'b1;
        bus.c    = 3'd0;
        #3;
        chk("rst_rfd", 8'(bus.rfd), 8'd1);
        chk_res("rst", 1'b0, 6'd0, 3'd0, 3'd0);
        #20 reset = 1'b0;
        @(posedge clock); #1;

        // table-driven full handshakes
        for (int i = 0; i < 24; i++) begin
            xfer(tbl[i].s, 0);
            chk_res($sformatf("tbl%0d", i), tbl[i].ok, tbl[i].sum, tbl[i].avg, tbl[i].mx);
            idle1();
        end

        // dav_ held low 10 cycles: one transfer counted, changed c ignored
        xfer(3'd3, 10);
        chk_res("hold_first", 1'b0, 6'd0, 3'd0, 3'd0);
        idle1();
        for (int i = 0; i < 7; i++) begin
            xfer(3'd1, 0);
            if (i < 6) idle1();
        end
        chk_res("hold_blk", 1'b1, 6'd10, 3'd1, 3'd3);
        idle1();

        // block of 2s, then next sample offered in the ok cycle
        for (int i = 0; i < 8; i++) begin
            xfer(3'd2, 0);
            if (i < 7) idle1();
        end
        chk_res("b2b_blk", 1'b1, 6'd16, 3'd2, 3'd2);
        bus.dav_ = 1'b0;
        bus.c    = 3'd5;
        @(posedge clock); #1;
        chk("b2b_ok_drop", 8'(bus.ok), 8'd0);
        chk("b2b_rfd_r1", 8'(bus.rfd), 8'd1);
        bus.c = 3'd2;
        @(posedge clock); #1;
        chk("b2b_rfd_fall", 8'(bus.rfd), 8'd0);
        bus.dav_ = 1'b1;
        @(posedge clock); #1;
        chk("b2b_rfd_rise", 8'(bus.rfd), 8'd1);
        chk("b2b_ok_first", 8'(bus.ok), 8'd0);
        for (int i = 0; i < 7; i++) begin
            idle1();
            xfer(3'd4, 0);
        end
        chk_res("b2b_next", 1'b1, 6'd33, 3'd4, 3'd5);
        idle1();

        // reset asynchronously while in R2 with CNT=5
        for (int i = 0; i < 4; i++) begin
            xfer(3'd1, 0);
            idle1();
        end
        bus.dav_ = 1'b0;
        bus.c    = 3'd1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("r2_rfd_low", 8'(bus.rfd), 8'd0);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_rfd", 8'(bus.rfd), 8'd1);
        chk_res("mid_rst", 1'b0, 6'd0, 3'd0, 3'd0);
        bus.dav_ = 1'b1;
        @(posedge clock); #3 reset = 1'b0;
        @(posedge clock); #1;
        for (int i = 0; i < 8; i++) begin
            xfer(3'd6, 0);
            if (i < 7) begin
                chk("post_rst_no_ok", 8'(bus.ok), 8'd0);
                idle1();
            end
        end
        chk_res("post_rst_blk", 1'b1, 6'd48, 3'd6, 3'd6);
        idle1();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/dav_rx_accum.md
Name: dav_rx_accum

Overview:
- Consumer end of the dav_/rfd output handshake, i.e. the block that sits on a c/dav_/rfd channel of the bit-counting producer.
- Receives 3-bit samples one at a time. Each block of NSAMP samples is summed and averaged.
- Publishes the block sum and average with a one-cycle strobe for downstream logic.
- One instance per producer channel.

Parameters:
- LOG2N, 3, log2 of samples per block. NSAMP = 2**LOG2N. Legal range 1..5.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- dav_  in  1  data valid from producer, active low
- c  in  3  sample from producer, valid while dav_=0
- rfd  out  1  ready-for-data to producer, active high
- sum  out  3+LOG2N  sum of the last completed block
- avg  out  3  sum >> LOG2N, truncated
- ok  out  1  one-cycle strobe: sum/avg just updated
- max  out  3  present only with MAX_EN; largest sample of last completed block

Behaviour:
- Reset values (async, on reset=1):
  - STAR=R0, rfd=1, ok=0, sum=0, avg=0, max=0.
  - Internal: ACC=0, CNT=0, C=0, MX=0.
- All outputs are registered. No combinational path from inputs to outputs.
- State R0 (idle, rfd=1):
  - ok<=0.
  - If dav_==0: C<=c, go R1. Otherwise stay in R0.
- State R1 (accept):
  - rfd<=0, ACC<=ACC+C, CNT<=CNT+1, MX<=max(MX,C).
  - Go R2 unconditionally. R1 lasts exactly one clock.
- State R2 (wait for dav_ to rise):
  - Stay while dav_==0.
  - When dav_==1: rfd<=1.
    - If CNT==NSAMP (CNT is LOG2N+1 bits wide): sum<=ACC, avg<=ACC[LOG2N+2:LOG2N], max<=MX, ok<=1, ACC<=0, CNT<=0, MX<=0.
  - Go R0.
- Handshake rules:
  - c is sampled only on the R0->R1 edge. Later changes to c are ignored.
  - rfd falls 2 clocks after dav_ is seen low. rfd rises 1 clock after dav_ is seen high.
  - The producer must not drop dav_ while rfd=0 until the previous dav_ has risen. R2 enforces this by waiting.
- ok:
  - High exactly one cycle, in the first R0 cycle after the block-closing transfer.
  - If dav_ is already low in that cycle, the next sample is still accepted normally. ok still lasts exactly one cycle.
- Width and overflow:
  - ACC holds at most 7*NSAMP and cannot overflow.
  - CNT counts up to NSAMP and then clears. No wrap inside a block.
- Reset mid-operation: a partial block is discarded, rfd returns to 1, and outputs return to 0.
- Unused state encodings go to R0.

Optional Feature:
- Macro DAV_RX_MAX_EN.
- Defined:
  - MX register and max port exist.
  - max updates together with sum/avg.
  - MX compare is unsigned 3-bit.
- Undefined:
  - No MX register and no max port.
  - All other behaviour is identical, cycle for cycle.

Test Plan:
- Reset asserted asynchronously mid-R2 with CNT=5 -> rfd=1, sum=0, avg=0, ok=0 immediately; the next block starts from CNT=0.
- LOG2N=3, samples 1,2,3,4,5,6,7,0 with full handshakes -> after the 8th dav_ rise: sum=28, avg=3, ok for exactly 1 cycle; with macro, max=7.
- Eight samples of 7 -> sum=56, avg=7. Then eight samples of 0 -> sum=0, avg=0; max=0 with macro.
- dav_ held low 10 cycles after capture -> rfd stays 0 and the state stays R2; c changed during the hold is not accumulated; one transfer is counted.
- dav_ low in the same cycle ok=1 -> ok still lasts 1 cycle, that sample becomes sample 1 of the next block, and the next sum is correct.
- Check timing on every transfer: rfd falls exactly 2 clocks after dav_ falls and rises exactly 1 clock after dav_ rises.
